// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX operand forwarding and hazard stall.
// Define ID_EX_FWD_EN for EX/MEM and MEM/WB forwarding; otherwise RAW hazards stall until writeback.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int CW = 5
) (
    input  logic          clk_i,
    input  logic          rst_n,
    input  logic          id_valid_i,
    input  logic [DW-1:0] id_rs_data_i,
    input  logic [DW-1:0] id_rt_data_i,
    input  logic [DW-1:0] id_imm_i,
    input  logic [RW-1:0] id_rs_i,
    input  logic [RW-1:0] id_rt_i,
    input  logic [RW-1:0] id_rd_i,
    input  logic [CW-1:0] id_ctrl_i,
    input  logic [4:0]    id_shamt_i,
    input  logic          id_alu_src_i,
    input  logic          id_uses_rs_i,
    input  logic          id_uses_rt_i,
    input  logic          id_reg_write_i,
    input  logic          id_mem_read_i,
    input  logic          id_mem_write_i,
    input  logic          flush_i,
    input  logic [RW-1:0] exmem_rd_i,
    input  logic          exmem_reg_write_i,
    input  logic [DW-1:0] exmem_result_i,
    input  logic [RW-1:0] memwb_rd_i,
    input  logic          memwb_reg_write_i,
    input  logic [DW-1:0] memwb_result_i,
    output logic [DW-1:0] src1_o,
    output logic [DW-1:0] src2_o,
    output logic [CW-1:0] ctrl_o,
    output logic [4:0]    shamt_o,
    output logic [DW-1:0] ex_store_data_o,
    output logic [RW-1:0] ex_rd_o,
    output logic          ex_valid_o,
    output logic          ex_reg_write_o,
    output logic          ex_mem_read_o,
    output logic          ex_mem_write_o,
    output logic          stall_o
);
    logic [DW-1:0] rs_data, rt_data, imm, fwd_rs, fwd_rt;
    logic [RW-1:0] rs, rt;
    logic          alu_src, load;

    function automatic logic hit(input logic en, input logic [RW-1:0] rd, input logic [RW-1:0] r);
        return en && rd != '0 && rd == r;
    endfunction

    assign load = id_valid_i && !flush_i && !stall_o;

    // Any cycle that does not load the ID instruction loads an all-zero bubble.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_o     <= 1'b0;
            ex_reg_write_o <= 1'b0;
            ex_mem_read_o  <= 1'b0;
            ex_mem_write_o <= 1'b0;
            ctrl_o         <= '0;
            shamt_o        <= '0;
            ex_rd_o        <= '0;
            rs             <= '0;
            rt             <= '0;
            rs_data        <= '0;
            rt_data        <= '0;
            imm            <= '0;
            alu_src        <= 1'b0;
        end else begin
            ex_valid_o     <= load;
            ex_reg_write_o <= load && id_reg_write_i;
            ex_mem_read_o  <= load && id_mem_read_i;
            ex_mem_write_o <= load && id_mem_write_i;
            ctrl_o         <= load ? id_ctrl_i : '0;
            shamt_o        <= load ? id_shamt_i : '0;
            ex_rd_o        <= load ? id_rd_i : '0;
            rs             <= load ? id_rs_i : '0;
            rt             <= load ? id_rt_i : '0;
            rs_data        <= load ? id_rs_data_i : '0;
            rt_data        <= load ? id_rt_data_i : '0;
            imm            <= load ? id_imm_i : '0;
            alu_src        <= load && id_alu_src_i;
        end
    end

`ifdef ID_EX_FWD_EN
    assign fwd_rs = hit(exmem_reg_write_i, exmem_rd_i, rs) ? exmem_result_i :
                    hit(memwb_reg_write_i, memwb_rd_i, rs) ? memwb_result_i : rs_data;
    assign fwd_rt = hit(exmem_reg_write_i, exmem_rd_i, rt) ? exmem_result_i :
                    hit(memwb_reg_write_i, memwb_rd_i, rt) ? memwb_result_i : rt_data;
    assign stall_o = id_valid_i && !flush_i && ex_valid_o && ex_mem_read_o &&
                     ((id_uses_rs_i && hit(1'b1, ex_rd_o, id_rs_i)) ||
                      (id_uses_rt_i && hit(1'b1, ex_rd_o, id_rt_i)));
`else
    logic ex_w, unused_ok;
    assign ex_w      = ex_valid_o && ex_reg_write_o;
    assign fwd_rs    = rs_data;
    assign fwd_rt    = rt_data;
    // Without forwarding, wait until the producer has left both EX and EX/MEM.
    assign stall_o   = id_valid_i && !flush_i &&
                       ((id_uses_rs_i && (hit(ex_w, ex_rd_o, id_rs_i) || hit(exmem_reg_write_i, exmem_rd_i, id_rs_i))) ||
                        (id_uses_rt_i && (hit(ex_w, ex_rd_o, id_rt_i) || hit(exmem_reg_write_i, exmem_rd_i, id_rt_i))));
    assign unused_ok = ^{exmem_result_i, memwb_rd_i, memwb_reg_write_i, memwb_result_i};
`endif

    assign src1_o          = fwd_rs;
    assign src2_o          = alu_src ? imm : fwd_rt;
    assign ex_store_data_o = fwd_rt;
endmodule
